// File: rtl/core_seq_pkg.sv
// Shared types for the rv32 multi-cycle control sequencer.
package core_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    TRAP   = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_TARGET = 2'b01,
    PC_TRAP   = 2'b10
  } pc_sel_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_ILLEGAL = 2'b01,
    CAUSE_IMEM_TO = 2'b10,
    CAUSE_DMEM_TO = 2'b11
  } trap_cause_t;

  // Counter width able to hold n-1; never narrower than one bit.
  function automatic int cnt_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/core_seq_if.sv
// Memory handshakes, decoder inputs and core control strobes of the sequencer.
interface core_seq_if #(parameter int INSTRET_W = 32);

  logic                 run;
  logic                 imem_req;
  logic                 imem_ack;
  logic                 dmem_req;
  logic                 dmem_we;
  logic                 dmem_ack;
  logic                 dec_reg_write;
  logic                 dec_mem_read;
  logic                 dec_mem_write;
  logic                 dec_branch;
  logic                 dec_jump;
  logic                 dec_illegal;
  logic                 br_taken;
  logic                 ir_we;
  logic                 pc_we;
  logic [1:0]           pc_sel;
  logic                 rf_we;
  logic                 retire;
  logic                 trap;
  logic [1:0]           trap_cause;
  logic [INSTRET_W-1:0] instret;
  logic [2:0]           state_o;

  modport master (
    input  run, imem_ack, dmem_ack,
    input  dec_reg_write, dec_mem_read, dec_mem_write,
    input  dec_branch, dec_jump, dec_illegal, br_taken,
    output imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel,
    output rf_we, retire, trap, trap_cause, instret, state_o
  );

  modport slave (
    output run, imem_ack, dmem_ack,
    output dec_reg_write, dec_mem_read, dec_mem_write,
    output dec_branch, dec_jump, dec_illegal, br_taken,
    input  imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel,
    input  rf_we, retire, trap, trap_cause, instret, state_o
  );

endinterface

// File: rtl/seq_timeout_counter.sv
// Memory-wait watchdog: down-counter reloaded on clear, expired on the last
// allowed wait cycle so the caller can let a same-cycle ack win.
module seq_timeout_counter
  import core_seq_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = cnt_width(MEM_TIMEOUT);
  localparam logic [CW-1:0] LOAD = (MEM_TIMEOUT > 0) ? CW'(MEM_TIMEOUT - 1) : '0;

  logic [CW-1:0] cnt;

  // Reload while idle or acknowledged, count down one per unacknowledged cycle.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= LOAD;
    end else if (enable && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (MEM_TIMEOUT != 0) && (cnt == '0);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer for the rv32 core.
//
//   state  | meaning
//   IDLE   | stopped, waiting for run
//   FETCH  | imem request outstanding, IR loads on ack
//   DECODE | decoder settles, illegal opcodes trap here
//   EXEC   | ALU cycle, picks MEM or WB
//   MEM    | dmem request outstanding, stores retire on ack
//   WB     | register write-back and PC update, retires
//   TRAP   | PC to trap vector, cause latched
module core_sequencer
  import core_seq_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int INSTRET_W   = 32
) (
  input  logic          clk,
  input  logic          rst,
  core_seq_if.master    bus
);

  state_t               state, state_nxt;
  trap_cause_t          cause_nxt, cause_q;
  logic                 cause_we;
  logic [INSTRET_W-1:0] instret_q;
  logic                 imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, retire, trap;
  pc_sel_t              pc_sel;
  logic                 waiting, expired;

  // Only an unacknowledged request cycle advances the watchdog.
  assign waiting = ((state == FETCH) && !bus.imem_ack) ||
                   ((state == MEM)   && !bus.dmem_ack);

  seq_timeout_counter #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (!waiting),
    .enable  (waiting),
    .expired (expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and strobe decode.
  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = PC_PLUS4;
    rf_we     = 1'b0;
    retire    = 1'b0;
    trap      = 1'b0;
    cause_we  = 1'b0;
    cause_nxt = CAUSE_NONE;
    unique case (state)
      IDLE: begin
        if (bus.run) state_nxt = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (bus.imem_ack) begin
          ir_we     = 1'b1;
          state_nxt = DECODE;
        end else if (expired) begin
          cause_we  = 1'b1;
          cause_nxt = CAUSE_IMEM_TO;
          state_nxt = TRAP;
        end
      end
      DECODE: begin
        if (bus.dec_illegal) begin
          cause_we  = 1'b1;
          cause_nxt = CAUSE_ILLEGAL;
          state_nxt = TRAP;
        end else begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        state_nxt = (bus.dec_mem_read || bus.dec_mem_write) ? MEM : WB;
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = bus.dec_mem_write;
        if (bus.dmem_ack) begin
          if (bus.dec_mem_write) begin
            pc_we     = 1'b1;
            retire    = 1'b1;
            state_nxt = bus.run ? FETCH : IDLE;
          end else begin
            state_nxt = WB;
          end
        end else if (expired) begin
          cause_we  = 1'b1;
          cause_nxt = CAUSE_DMEM_TO;
          state_nxt = TRAP;
        end
      end
      WB: begin
        rf_we     = bus.dec_reg_write;
        pc_we     = 1'b1;
        retire    = 1'b1;
        pc_sel    = (bus.dec_jump || (bus.dec_branch && bus.br_taken)) ? PC_TARGET : PC_PLUS4;
        state_nxt = bus.run ? FETCH : IDLE;
      end
      TRAP: begin
        trap      = 1'b1;
        pc_we     = 1'b1;
        pc_sel    = PC_TRAP;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Cause is latched on entry to TRAP so it is already valid during the pulse.
  always_ff @(posedge clk) begin
    if (rst)           cause_q <= CAUSE_NONE;
    else if (cause_we) cause_q <= cause_nxt;
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst)         instret_q <= '0;
    else if (retire) instret_q <= instret_q + 1'b1;
  end

  assign bus.imem_req   = imem_req;
  assign bus.dmem_req   = dmem_req;
  assign bus.dmem_we    = dmem_we;
  assign bus.ir_we      = ir_we;
  assign bus.pc_we      = pc_we;
  assign bus.pc_sel     = pc_sel;
  assign bus.rf_we      = rf_we;
  assign bus.retire     = retire;
  assign bus.trap       = trap;
  assign bus.trap_cause = cause_q;
  assign bus.instret    = instret_q;
  assign bus.state_o    = state;

endmodule

// File: tb/tb_core_sequencer.sv
// Testbench for core_sequencer: instruction-level plan expanded into a
// per-cycle stimulus/expectation trace, replayed against the DUT.
module tb_core_sequencer;

  localparam int T  = 16;
  localparam int IW = 4;

  localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_EXEC = 3,
                 S_MEM = 4, S_WB = 5, S_TRAP = 6;

  localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BRANCH = 3, K_JUMP = 4,
                 K_ILLEGAL = 5, K_ITO = 6, K_DTO = 7, K_RST = 8;

  typedef struct packed {
    logic rst, run, imem_ack, dmem_ack;
    logic reg_write, mem_read, mem_write, branch, jump, illegal, br_taken;
  } stim_t;

  typedef struct packed {
    logic          chk;
    logic [2:0]    state;
    logic          imem_req, dmem_req, dmem_we, ir_we, pc_we;
    logic [1:0]    pc_sel;
    logic          rf_we, retire, trap;
    logic [1:0]    cause;
    logic [IW-1:0] instret;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  core_seq_if #(.INSTRET_W(IW)) bus ();

  core_sequencer #(.MEM_TIMEOUT(T), .INSTRET_W(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  stim_t stim_q[$];
  exp_t  exp_q[$];
  int    lit_cyc[$];
  int    lit_sel[$];
  int    lit_val[$];
  string lit_name[$];

  int       vectors = 0;
  int       errors  = 0;
  int       m_instret = 0;
  logic [1:0] m_cause = 2'b00;
  bit       at_fetch = 1'b0;

  task automatic chk(input string nm, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic stim_t rnd_stim();
    logic [31:0] r;
    stim_t s;
    r = $urandom;
    s = stim_t'(r[$bits(stim_t)-1:0]);
    s.rst = 1'b0;
    return s;
  endfunction

  function automatic stim_t overlay(input stim_t s, input stim_t d);
    stim_t o;
    o = s;
    o.reg_write = d.reg_write;
    o.mem_read  = d.mem_read;
    o.mem_write = d.mem_write;
    o.branch    = d.branch;
    o.jump      = d.jump;
    o.illegal   = d.illegal;
    o.br_taken  = d.br_taken;
    return o;
  endfunction

  function automatic exp_t mk(input int st);
    exp_t e;
    e = '0;
    e.chk     = 1'b1;
    e.state   = 3'(st);
    e.cause   = m_cause;
    e.instret = IW'(m_instret);
    return e;
  endfunction

  task automatic push(input stim_t s, input exp_t e);
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic lit(input int sel, input int val, input string nm);
    lit_cyc.push_back(stim_q.size());
    lit_sel.push_back(sel);
    lit_val.push_back(val);
    lit_name.push_back(nm);
  endtask

  task automatic do_trap(input stim_t d, input logic [1:0] c);
    exp_t e;
    m_cause  = c;
    e        = mk(S_TRAP);
    e.trap   = 1'b1;
    e.pc_we  = 1'b1;
    e.pc_sel = 2'b10;
    push(overlay(rnd_stim(), d), e);
    at_fetch = 1'b0;
  endtask

  task automatic do_retire(input bit r);
    m_instret = (m_instret + 1) % (1 << IW);
    at_fetch  = r;
  endtask

  // Expand one instruction into the cycles it must take.
  task automatic plan(input int kind, input int idle_n, input int fw, input int mw,
                      input bit taken, input bit run_end, input bit rw);
    stim_t d, s;
    exp_t  e;
    int    last;
    d = '0;
    d.reg_write = rw;
    d.br_taken  = taken;
    case (kind)
      K_LOAD, K_RST: d.mem_read = 1'b1;
      K_STORE:       d.mem_write = 1'b1;
      K_BRANCH:      begin d.branch = 1'b1; d.reg_write = 1'b0; end
      K_JUMP:        d.jump = 1'b1;
      K_ILLEGAL:     d.illegal = 1'b1;
      K_DTO:         if (taken) d.mem_write = 1'b1; else d.mem_read = 1'b1;
      default:       ;
    endcase
    if (!at_fetch) begin
      for (int k = 0; k <= idle_n; k++) begin
        s = rnd_stim();
        s.run = (k == idle_n);
        push(s, mk(S_IDLE));
      end
    end
    if (kind == K_ITO) begin
      for (int k = 0; k < T; k++) begin
        s = rnd_stim();
        s.imem_ack = 1'b0;
        e = mk(S_FETCH);
        e.imem_req = 1'b1;
        push(s, e);
      end
      do_trap(d, 2'b10);
      return;
    end
    for (int k = 0; k <= fw; k++) begin
      s = rnd_stim();
      s.imem_ack = (k == fw);
      e = mk(S_FETCH);
      e.imem_req = 1'b1;
      e.ir_we    = (k == fw);
      push(s, e);
    end
    push(overlay(rnd_stim(), d), mk(S_DECODE));
    if (d.illegal) begin
      do_trap(d, 2'b01);
      return;
    end
    push(overlay(rnd_stim(), d), mk(S_EXEC));
    if (d.mem_read || d.mem_write) begin
      last = (kind == K_DTO) ? T - 1 : mw;
      for (int k = 0; k <= last; k++) begin
        s = overlay(rnd_stim(), d);
        e = mk(S_MEM);
        e.dmem_req = 1'b1;
        e.dmem_we  = d.mem_write;
        s.dmem_ack = (kind != K_DTO) && (kind != K_RST) && (k == mw);
        if (kind == K_RST && k == mw) begin
          s.rst = 1'b1;
          push(s, e);
          m_instret = 0;
          m_cause   = 2'b00;
          at_fetch  = 1'b0;
          return;
        end
        if (s.dmem_ack && d.mem_write) begin
          s.run    = run_end;
          e.pc_we  = 1'b1;
          e.retire = 1'b1;
          push(s, e);
          do_retire(run_end);
          return;
        end
        push(s, e);
      end
      if (kind == K_DTO) begin
        do_trap(d, 2'b11);
        return;
      end
    end
    s = overlay(rnd_stim(), d);
    s.run = run_end;
    e = mk(S_WB);
    e.rf_we  = d.reg_write;
    e.pc_we  = 1'b1;
    e.retire = 1'b1;
    e.pc_sel = (d.jump || (d.branch && d.br_taken)) ? 2'b01 : 2'b00;
    push(s, e);
    do_retire(run_end);
  endtask

  task automatic plan_len(input string nm, input int expect_len, input int kind, input int idle_n,
                          input int fw, input int mw, input bit taken, input bit run_end, input bit rw);
    int n0;
    n0 = stim_q.size();
    plan(kind, idle_n, fw, mw, taken, run_end, rw);
    chk(nm, stim_q.size() - n0, expect_len);
  endtask

  function automatic int lit_actual(input int sel);
    case (sel)
      0:       return int'(bus.instret);
      1:       return int'(bus.trap_cause);
      2:       return int'(bus.state_o);
      3:       return int'(bus.dmem_req);
      default: return int'(bus.imem_req);
    endcase
  endfunction

  task automatic apply(input stim_t s);
    rst               = s.rst;
    bus.run           = s.run;
    bus.imem_ack      = s.imem_ack;
    bus.dmem_ack      = s.dmem_ack;
    bus.dec_reg_write = s.reg_write;
    bus.dec_mem_read  = s.mem_read;
    bus.dec_mem_write = s.mem_write;
    bus.dec_branch    = s.branch;
    bus.dec_jump      = s.jump;
    bus.dec_illegal   = s.illegal;
    bus.br_taken      = s.br_taken;
  endtask

  task automatic compare(input int i, input exp_t e);
    chk($sformatf("state_o[%0d]", i),   int'(bus.state_o),    int'(e.state));
    chk($sformatf("imem_req[%0d]", i),  int'(bus.imem_req),   int'(e.imem_req));
    chk($sformatf("dmem_req[%0d]", i),  int'(bus.dmem_req),   int'(e.dmem_req));
    if (e.dmem_req) chk($sformatf("dmem_we[%0d]", i), int'(bus.dmem_we), int'(e.dmem_we));
    chk($sformatf("ir_we[%0d]", i),     int'(bus.ir_we),      int'(e.ir_we));
    chk($sformatf("pc_we[%0d]", i),     int'(bus.pc_we),      int'(e.pc_we));
    if (e.pc_we) chk($sformatf("pc_sel[%0d]", i), int'(bus.pc_sel), int'(e.pc_sel));
    chk($sformatf("rf_we[%0d]", i),     int'(bus.rf_we),      int'(e.rf_we));
    chk($sformatf("retire[%0d]", i),    int'(bus.retire),     int'(e.retire));
    chk($sformatf("trap[%0d]", i),      int'(bus.trap),       int'(e.trap));
    chk($sformatf("trap_cause[%0d]", i), int'(bus.trap_cause), int'(e.cause));
    chk($sformatf("instret[%0d]", i),   int'(bus.instret),    int'(e.instret));
  endtask

  initial begin
    stim_t s0;
    exp_t  e0;
    int    r, kind;
    apply('0);
    rst = 1'b1;

    s0 = '0;
    s0.rst = 1'b1;
    e0 = '0;
    push(s0, e0);
    push(s0, mk(S_IDLE));

    plan_len("len_alu",        5, K_ALU,     0, 0,     0,     0, 1, 1);
    lit(0, 1, "lit_instret_after_alu");
    lit(2, S_FETCH, "lit_fetch_after_alu");
    plan_len("len_load_wait3", 8, K_LOAD,    0, 0,     3,     0, 1, 1);
    lit(0, 2, "lit_instret_after_load");
    plan_len("len_store",      4, K_STORE,   0, 0,     0,     0, 1, 1);
    lit(0, 3, "lit_instret_after_store");
    plan_len("len_br_taken",   4, K_BRANCH,  0, 0,     0,     1, 1, 0);
    plan_len("len_br_not",     4, K_BRANCH,  0, 0,     0,     0, 0, 0);
    lit(2, S_IDLE, "lit_idle_after_run_low");
    lit(0, 5, "lit_instret_after_branches");
    plan_len("len_illegal",    4, K_ILLEGAL, 0, 0,     0,     0, 1, 1);
    lit(1, 1, "lit_cause_illegal");
    lit(0, 5, "lit_instret_kept_on_trap");
    lit(2, S_IDLE, "lit_idle_after_trap");
    plan_len("len_imem_to",   18, K_ITO,     0, 0,     0,     0, 1, 1);
    lit(1, 2, "lit_cause_imem_to");
    lit(4, 0, "lit_imem_req_dropped");
    plan_len("len_fetch_last", 20, K_ALU,    0, T - 1, 0,     0, 1, 1);
    lit(0, 6, "lit_instret_last_ack");
    plan_len("len_store_last", 19, K_STORE,  0, 0,     T - 1, 0, 1, 0);
    lit(0, 7, "lit_instret_store_last");
    plan_len("len_dmem_to",   20, K_DTO,     0, 0,     0,     1, 1, 0);
    lit(1, 3, "lit_cause_dmem_to");
    plan_len("len_jump",       5, K_JUMP,    0, 0,     0,     0, 1, 1);
    plan_len("len_rst_mem",    6, K_RST,     0, 0,     2,     0, 1, 1);
    lit(2, S_IDLE, "lit_rst_state");
    lit(3, 0, "lit_rst_dmem_req");
    lit(0, 0, "lit_rst_instret");
    lit(1, 0, "lit_rst_cause");

    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 19);
      if (r < 5)       kind = K_ALU;
      else if (r < 9)  kind = K_LOAD;
      else if (r < 12) kind = K_STORE;
      else if (r < 15) kind = K_BRANCH;
      else if (r < 17) kind = K_JUMP;
      else if (r < 18) kind = K_ILLEGAL;
      else if (r < 19) kind = K_ITO;
      else             kind = K_DTO;
      plan(kind, $urandom_range(0, 2),
           ($urandom_range(0, 7) == 0) ? $urandom_range(0, T - 1) : $urandom_range(0, 2),
           ($urandom_range(0, 7) == 0) ? $urandom_range(0, T - 1) : $urandom_range(0, 2),
           1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end
    s0 = rnd_stim();
    s0.run = 1'b0;
    push(s0, (at_fetch) ? mk(S_FETCH) : mk(S_IDLE));
    if (at_fetch) begin
      exp_q[exp_q.size() - 1].imem_req = 1'b1;
      stim_q[stim_q.size() - 1].imem_ack = 1'b0;
    end

    for (int i = 0; i < stim_q.size(); i++) begin
      @(negedge clk);
      apply(stim_q[i]);
      #1;
      if (exp_q[i].chk) compare(i, exp_q[i]);
      for (int j = 0; j < lit_cyc.size(); j++) begin
        if (lit_cyc[j] == i) chk(lit_name[j], lit_actual(lit_sel[j]), lit_val[j]);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
